// File: rtl/mcpu_io_pkg.sv
// Shared definitions for the memory-mapped cpu I/O responders:
// register offsets, STATUS bit positions and UART tx state codes.
package mcpu_io_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIVL   = 2'd2;
   localparam logic [1:0] REG_DIVH   = 2'd3;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_PAR   = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_e;

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through read port.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Registers: +0 DATA, +1 STATUS, +2 DIV[7:0], +3 DIV[15:8].
module bus_uart_tx
   import mcpu_io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter logic [15:0] CLK_DIV    = 16'd433,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic [7:0]  wdata,
   input  logic        read,
   output logic [7:0]  rdata,
   output logic        hit,
   output logic        txd,
   output logic        irq
);

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_BUILD = 1'b1;
`else
   localparam logic PAR_BUILD = 1'b0;
`endif

   tx_state_e   state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
   logic        par_q, par_d;
`endif

   logic [1:0]  offset;
   logic        wr_en, wr_data, wr_stat, wr_divl, wr_divh;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic        bit_end, busy;
   logic [7:0]  status;

   assign hit     = (address[15:2] == BASE_ADDR[15:2]);
   assign offset  = address[1:0];
   assign wr_en   = hit & ~read;
   assign wr_data = wr_en & (offset == REG_DATA);
   assign wr_stat = wr_en & (offset == REG_STATUS);
   assign wr_divl = wr_en & (offset == REG_DIVL);
   assign wr_divh = wr_en & (offset == REG_DIVH);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_data),
      .wdata_i (wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bit_end = (cnt_q == '0);
   assign busy    = (state_q != S_IDLE);
   assign irq     = fifo_empty & ~busy;

   always_comb begin
      status           = '0;
      status[ST_BUSY]  = busy;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_OVF]   = ovf_q;
      status[ST_PAR]   = PAR_BUILD;
   end

   always_comb begin
      rdata = '0;
      if (hit && read) begin
         unique case (offset)
            REG_DATA:   rdata = '0;
            REG_STATUS: rdata = status;
            REG_DIVL:   rdata = div_q[7:0];
            REG_DIVH:   rdata = div_q[15:8];
         endcase
      end
   end

   // A dropped push (full, no pop this cycle) outranks a STATUS write clear
   always_comb begin
      ovf_d = ovf_q;
      div_d = div_q;
      if (wr_stat) ovf_d = 1'b0;
      if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
      if (wr_divl) div_d[7:0]  = wdata;
      if (wr_divh) div_d[15:8] = wdata;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      if (bit_end) cnt_d = div_q;
      else         cnt_d = cnt_q - 16'd1;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            if (!fifo_empty) begin
               state_d  = S_START;
               fifo_pop = 1'b1;
               shift_d  = fifo_head;
               cnt_d    = div_q;
`ifdef UART_TX_PARITY_EN
               par_d    = even_par(fifo_head);
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  state_d  = S_START;
                  fifo_pop = 1'b1;
                  shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                  par_d    = even_par(fifo_head);
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      txd = 1'b1;
      unique case (state_q)
         S_START: txd = 1'b0;
         S_DATA:  txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd = par_q;
`endif
         default: txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= CLK_DIV;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx (define UART_TX_PARITY_EN for 8E1).
module tb_bus_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [7:0] PARB = 8'h10;
`else
   localparam int NB = 10;
   localparam logic [7:0] PARB = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address;
   logic [7:0]  wdata;
   logic        read;
   logic [7:0]  rdata;
   logic        hit;
   logic        txd;
   logic        irq;

   int checks = 0;
   int errors = 0;

   bus_uart_tx dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .wdata   (wdata),
      .read    (read),
      .rdata   (rdata),
      .hit     (hit),
      .txd     (txd),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  rdata;
      logic        hit;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a;
      wdata   = d;
      read    = 1'b0;
      @(posedge clk);
      #1;
      read    = 1'b1;
      address = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] exp,
                     input string nm);
      @(negedge clk);
      address = a;
      read    = 1'b1;
      #1;
      chk(nm, rdata, exp);
      address = 16'h0000;
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (i == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   // Expects the next negedge to be the first cycle of the start bit
   task automatic check_frame(input logic [7:0] b, input int div,
                              input string nm);
      int ibad;
      ibad = 0;
      for (int i = 0; i < NB; i++) begin
         int bad;
         bad = 0;
         for (int c = 0; c <= div; c++) begin
            @(negedge clk);
            if (txd !== exp_bit(b, i)) bad++;
            if (irq !== 1'b0) ibad++;
         end
         chk($sformatf("%s_bit%0d_badcycles", nm, i), bad, 0);
      end
      chk($sformatf("%s_irq_busy_badcycles", nm), ibad, 0);
   endtask

   initial begin
      vt[0] = '{16'hFF00, 8'h00, 1'b1};
      vt[1] = '{16'hFF01, 8'h04 | PARB, 1'b1};
      vt[2] = '{16'hFF02, 8'hB1, 1'b1};
      vt[3] = '{16'hFF03, 8'h01, 1'b1};
      vt[4] = '{16'hFEFF, 8'h00, 1'b0};
      vt[5] = '{16'hFF04, 8'h00, 1'b0};
      vt[6] = '{16'h0001, 8'h00, 1'b0};

      rst     = 1'b1;
      address = 16'h0000;
      wdata   = 8'h00;
      read    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", txd, 1'b1);
      chk("rst_irq", irq, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         address = vt[i].addr;
         #1;
         chk($sformatf("tbl%0d_rdata", i), rdata, vt[i].rdata);
         chk($sformatf("tbl%0d_hit", i), hit, vt[i].hit);
      end
      address = 16'h0000;

      wr(16'hFF02, 8'h03);
      wr(16'hFF03, 8'h00);
      rd(16'hFF02, 8'h03, "divl_rb");
      rd(16'hFF03, 8'h00, "divh_rb");

      wr(16'hFF00, 8'hA5);
      @(posedge clk);
      check_frame(8'hA5, 3, "a5");
      @(negedge clk);
      chk("a5_irq_after", irq, 1'b1);
      chk("a5_txd_after", txd, 1'b1);

      for (int i = 0; i < 6; i++) wr(16'hFF00, 8'h10 + 8'(i));
      rd(16'hFF01, 8'h0B | PARB, "ovf_status");
      wr(16'hFF01, 8'h00);
      rd(16'hFF01, 8'h03 | PARB, "ovf_cleared");
      begin
         int n;
         n = 0;
         while (irq !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
         end
         chk("drain_timeout", (n < 400), 1'b1);
      end
      rd(16'hFF01, 8'h04 | PARB, "drain_status");

      wr(16'hFF00, 8'h55);
      wr(16'hFF00, 8'hC3);
      check_frame(8'h55, 3, "b2b_first");
      check_frame(8'hC3, 3, "b2b_second");

      wr(16'hFF02, 8'h00);
      wr(16'hFF00, 8'h96);
      @(posedge clk);
      check_frame(8'h96, 0, "div0");

      wr(16'hFF02, 8'h03);
      wr(16'hFF00, 8'h00);
      wr(16'hFF00, 8'hFF);
      repeat (21) @(negedge clk);
      chk("mid_txd_bit4", txd, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_txd", txd, 1'b1);
      chk("mid_rst_irq", irq, 1'b1);
      address = 16'hFF01;
      #1;
      chk("mid_rst_status", rdata, 8'h04 | PARB);
      address = 16'hFF02;
      #1;
      chk("mid_rst_divl", rdata, 8'hB1);
      address = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      begin
         int bad;
         bad = 0;
         repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || irq !== 1'b1) bad++;
         end
         chk("post_rst_quiet_badcycles", bad, 0);
      end

`ifdef UART_TX_PARITY_EN
      wr(16'hFF02, 8'h01);
      wr(16'hFF03, 8'h00);
      rd(16'hFF01, 8'h14, "par_status");
      wr(16'hFF00, 8'h07);
      @(posedge clk);
      check_frame(8'h07, 1, "par07");
      wr(16'hFF00, 8'h03);
      @(posedge clk);
      check_frame(8'h03, 1, "par03");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
